// File: rtl/game_flow_controller_if.sv
// Game-side signal bundle for game_flow_controller: frame/keyboard/player inputs
// toward the controller and the flow status outputs back to the game modules.
interface game_flow_controller_if;
    logic       frame_clk;
    logic [7:0] keycode;
    logic       is_dead_girl;
    logic       is_diamond_eat;
    logic       at_exit;
    logic [3:0] status;
    logic       game_reset;
    logic       freeze;
    logic [4:0] fade_level;
    logic [3:0] score;
    logic       frame_tick;

    modport master (
        input  frame_clk, keycode, is_dead_girl, is_diamond_eat, at_exit,
        output status, game_reset, freeze, fade_level, score, frame_tick
    );

    modport slave (
        output frame_clk, keycode, is_dead_girl, is_diamond_eat, at_exit,
        input  status, game_reset, freeze, fade_level, score, frame_tick
    );
endinterface

// File: rtl/game_flow_controller.sv
// game_flow_controller: TITLE/PLAY/DYING/GAME_OVER/CLEAR flow, frame tick, score and death fade.
// Optional P-key pause state is built only when GAME_PAUSE_EN is defined.
module game_flow_controller #(
    parameter int FADE_FRAMES       = 32,
    parameter int DIAMONDS_TOTAL    = 1,
    parameter int CLEAR_HOLD_FRAMES = 120
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    game_flow_controller_if.master gf
);
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_ESC   = 8'h29;
`ifdef GAME_PAUSE_EN
    localparam logic [7:0] KEY_P     = 8'h13;
`endif
    localparam logic [4:0] FADE_LAST = 5'(FADE_FRAMES - 1);
    localparam logic [7:0] HOLD_LAST = 8'(CLEAR_HOLD_FRAMES - 1);
    localparam logic [3:0] DIAM_NEED = 4'(DIAMONDS_TOTAL);

    typedef enum logic [2:0] {
        S_TITLE = 3'd0,
        S_PLAY  = 3'd1,
        S_DYING = 3'd2,
        S_OVER  = 3'd3,
        S_CLEAR = 3'd4,
        S_PAUSE = 3'd5
    } state_t;

    state_t     state, state_next;
    logic       frame_sync_p0, frame_sync_p1, frame_sync_p2, frame_tick_p3;
    logic [7:0] key_prev;
    logic       diamond_prev;
    logic [4:0] fade_cnt;
    logic [7:0] hold_cnt;
    logic [3:0] score_q;
    logic       game_reset_q;
    logic       restart;
    logic       enter_press, esc_press, diamond_rise, exit_ok;
`ifdef GAME_PAUSE_EN
    logic       pause_press;
`endif

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // p0/p1 synchronize VGA_VS, p2 holds the previous sample, p3 is the registered tick
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_sync_p0 <= 1'b0;
            frame_sync_p1 <= 1'b0;
            frame_sync_p2 <= 1'b0;
            frame_tick_p3 <= 1'b0;
        end else begin
            frame_sync_p0 <= gf.frame_clk;
            frame_sync_p1 <= frame_sync_p0;
            frame_sync_p2 <= frame_sync_p1;
            frame_tick_p3 <= frame_sync_p1 & ~frame_sync_p2;
        end
    end

    assign enter_press  = (gf.keycode == KEY_ENTER) && (key_prev != KEY_ENTER);
    assign esc_press    = (gf.keycode == KEY_ESC) && (key_prev != KEY_ESC);
`ifdef GAME_PAUSE_EN
    assign pause_press  = (gf.keycode == KEY_P) && (key_prev != KEY_P);
`endif
    assign diamond_rise = gf.is_diamond_eat & ~diamond_prev;
    assign exit_ok      = gf.at_exit && (score_q >= DIAM_NEED);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_TITLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        restart    = 1'b0;
        case (state)
            S_TITLE: begin
                if (enter_press) begin
                    state_next = S_PLAY;
                    restart    = 1'b1;
                end
            end
            S_PLAY: begin
                // death outranks a simultaneous exit
                if (frame_tick_p3 && gf.is_dead_girl) begin
                    state_next = S_DYING;
                end else if (frame_tick_p3 && exit_ok) begin
                    state_next = S_CLEAR;
`ifdef GAME_PAUSE_EN
                end else if (pause_press) begin
                    state_next = S_PAUSE;
`endif
                end
            end
            S_DYING: begin
                if (frame_tick_p3 && (fade_cnt == FADE_LAST)) begin
                    state_next = S_OVER;
                end
            end
            S_OVER: begin
                if (enter_press) begin
                    state_next = S_PLAY;
                    restart    = 1'b1;
                end else if (esc_press) begin
                    state_next = S_TITLE;
                end
            end
            S_CLEAR: begin
                if (enter_press || (frame_tick_p3 && (hold_cnt == HOLD_LAST))) begin
                    state_next = S_TITLE;
                end
            end
`ifdef GAME_PAUSE_EN
            S_PAUSE: begin
                if (pause_press) begin
                    state_next = S_PLAY;
                end
            end
`endif
            default: state_next = S_TITLE;
        endcase
    end

    always_comb begin
        gf.status     = {1'b0, state};
        gf.freeze     = (state != S_PLAY);
        gf.fade_level = ((state == S_DYING) || (state == S_OVER)) ? fade_cnt : 5'd0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            key_prev     <= 8'h00;
            diamond_prev <= 1'b0;
            game_reset_q <= 1'b0;
            score_q      <= 4'd0;
            fade_cnt     <= 5'd0;
            hold_cnt     <= 8'd0;
        end else begin
            key_prev     <= gf.keycode;
            diamond_prev <= gf.is_diamond_eat;
            game_reset_q <= restart;

            if (restart) begin
                score_q <= 4'd0;
            end else if ((state == S_PLAY) && diamond_rise) begin
                score_q <= sat_inc4(score_q);
            end

            if ((state == S_PLAY) && (state_next == S_DYING)) begin
                fade_cnt <= 5'd0;
            end else if ((state == S_DYING) && frame_tick_p3 && (fade_cnt != FADE_LAST)) begin
                fade_cnt <= fade_cnt + 5'd1;
            end

            if ((state == S_PLAY) && (state_next == S_CLEAR)) begin
                hold_cnt <= 8'd0;
            end else if ((state == S_CLEAR) && frame_tick_p3) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end

    assign gf.game_reset = game_reset_q;
    assign gf.score      = score_q;
    assign gf.frame_tick = frame_tick_p3;
endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller (DIAMONDS_TOTAL=3): directed table, hand-written
// reset/pause sequences and randomized stimulus against a frame-level reference model.
module tb_game_flow_controller;
    localparam int FF = 32;
    localparam int DT = 3;
    localparam int CH = 120;
    localparam int FRAME_HALF = 4;
`ifdef GAME_PAUSE_EN
    localparam int P_ST = 5;
    localparam int P_SCORE = 0;
`else
    localparam int P_ST = 1;
    localparam int P_SCORE = 1;
`endif

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #10 Clk = ~Clk;

    game_flow_controller_if gf();

    game_flow_controller #(
        .FADE_FRAMES(FF),
        .DIAMONDS_TOTAL(DT),
        .CLEAR_HOLD_FRAMES(CH)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .gf(gf)
    );

    int n_tests = 0;
    int n_fail = 0;
    int n_resets = 0;
    int fc_cnt = 0;

    // reference model state (status codes as seen on the status port)
    int m_status, m_fade, m_hold, m_score;
    bit m_tick, m_grst, h1, h2, h3, m_pdia;
    logic [7:0] m_pkc;

    typedef struct {
        logic [7:0] kc;
        bit dead;
        bit dia;
        bit ex;
        int ncyc;
        int st;
        int sc;
        int fd;
        int rs;
    } rec_t;
    rec_t tbl[$];

    function automatic rec_t mk(logic [7:0] kc, bit dead, bit dia, bit ex, int n,
                                int st, int sc, int fd, int rs);
        rec_t r;
        r.kc = kc; r.dead = dead; r.dia = dia; r.ex = ex; r.ncyc = n;
        r.st = st; r.sc = sc; r.fd = fd; r.rs = rs;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_status = 0; m_fade = 0; m_hold = 0; m_score = 0;
        m_tick = 0; m_grst = 0; h1 = 0; h2 = 0; h3 = 0;
        m_pkc = 8'h00; m_pdia = 0;
    endfunction

    function automatic void model_edge();
        bit tick, enter, esc, pp, rise, restart;
        int nxt;
        if (!Reset_n) begin
            model_reset();
            return;
        end
        tick  = m_tick;
        enter = (gf.keycode == 8'h28) && (m_pkc != 8'h28);
        esc   = (gf.keycode == 8'h29) && (m_pkc != 8'h29);
        pp    = (gf.keycode == 8'h13) && (m_pkc != 8'h13);
        rise  = gf.is_diamond_eat && !m_pdia;
        restart = 0;
        nxt = m_status;
        case (m_status)
            0: if (enter) begin nxt = 1; restart = 1; end
            1: begin
                if (tick && gf.is_dead_girl) begin nxt = 2; m_fade = 0; end
                else if (tick && gf.at_exit && m_score >= DT) begin nxt = 4; m_hold = 0; end
`ifdef GAME_PAUSE_EN
                else if (pp) nxt = 5;
`endif
                if (rise) m_score = (m_score == 15) ? 15 : m_score + 1;
            end
            2: if (tick) begin
                if (m_fade == FF - 1) nxt = 3;
                else m_fade++;
            end
            3: if (enter) begin nxt = 1; restart = 1; end
               else if (esc) nxt = 0;
            4: begin
                if (tick) m_hold++;
                if (enter || m_hold == CH) nxt = 0;
            end
`ifdef GAME_PAUSE_EN
            5: if (pp) nxt = 1;
`endif
            default: nxt = 0;
        endcase
        if (restart) m_score = 0;
        m_status = nxt;
        m_grst = restart;
        m_tick = h2 && !h3;
        h3 = h2; h2 = h1; h1 = gf.frame_clk;
        m_pkc = gf.keycode;
        m_pdia = gf.is_diamond_eat;
    endfunction

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        if (gf.game_reset === 1'b1) n_resets++;
        chk("status", gf.status, m_status);
        chk("freeze", gf.freeze, (m_status != 1));
        chk("fade_level", gf.fade_level, (m_status == 2 || m_status == 3) ? m_fade : 0);
        chk("score", gf.score, m_score);
        chk("game_reset", gf.game_reset, m_grst);
        chk("frame_tick", gf.frame_tick, m_tick);
        fc_cnt++;
        if (fc_cnt == FRAME_HALF) begin
            fc_cnt = 0;
            gf.frame_clk = ~gf.frame_clk;
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic push_diamonds(input int rs);
        for (int k = 1; k <= 3; k++) begin
            tbl.push_back(mk(8'h00, 0, 1, 0, 2, 1, k, 0, rs));
            tbl.push_back(mk(8'h00, 0, 0, 0, 2, 1, k, 0, rs));
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        int base;
        logic [7:0] kc_opts [6];

        gf.frame_clk = 0; gf.keycode = 8'h00; gf.is_dead_girl = 0;
        gf.is_diamond_eat = 0; gf.at_exit = 0;
        model_reset();

        tbl.push_back(mk(8'h00, 0, 0, 0, 5, 0, 0, 0, 0));
        tbl.push_back(mk(8'h28, 0, 0, 0, 10, 1, 0, 0, 1));
        push_diamonds(1);
        tbl.push_back(mk(8'h00, 0, 0, 1, 16, 4, 3, 0, 1));
        tbl.push_back(mk(8'h00, 0, 0, 0, 800, 4, 3, 0, 1));
        tbl.push_back(mk(8'h00, 0, 0, 0, 240, 0, 3, 0, 1));
        tbl.push_back(mk(8'h28, 0, 0, 0, 4, 1, 0, 0, 2));
        tbl.push_back(mk(8'h00, 0, 0, 0, 4, 1, 0, 0, 2));
        push_diamonds(2);
        tbl.push_back(mk(8'h00, 1, 0, 1, 16, 2, 3, -1, 2));
        tbl.push_back(mk(8'h00, 0, 0, 0, 160, 2, 3, -1, 2));
        tbl.push_back(mk(8'h00, 0, 0, 0, 160, 3, 3, 31, 2));
        tbl.push_back(mk(8'h13, 0, 0, 0, 4, 3, 3, 31, 2));
        tbl.push_back(mk(8'h00, 0, 0, 0, 4, 3, 3, 31, 2));
        tbl.push_back(mk(8'h29, 0, 0, 0, 4, 0, 3, 0, 2));
        tbl.push_back(mk(8'h00, 0, 0, 0, 4, 0, 3, 0, 2));
        tbl.push_back(mk(8'h28, 0, 0, 0, 4, 1, 0, 0, 3));
        tbl.push_back(mk(8'h13, 0, 0, 0, 16, P_ST, 0, 0, 3));
        tbl.push_back(mk(8'h00, 0, 0, 0, 4, P_ST, 0, 0, 3));
        tbl.push_back(mk(8'h13, 0, 0, 0, 4, 1, 0, 0, 3));
        tbl.push_back(mk(8'h00, 0, 0, 0, 4, 1, 0, 0, 3));
        push_diamonds(3);
        tbl.push_back(mk(8'h00, 1, 0, 0, 16, 2, 3, -1, 3));
        tbl.push_back(mk(8'h00, 0, 0, 0, 320, 3, 3, 31, 3));
        tbl.push_back(mk(8'h28, 0, 0, 0, 4, 1, 0, 0, 4));
        tbl.push_back(mk(8'h00, 0, 0, 0, 4, 1, 0, 0, 4));

        // reset state
        #1;
        chk("rst_status", gf.status, 0);
        chk("rst_freeze", gf.freeze, 1);
        chk("rst_fade", gf.fade_level, 0);
        chk("rst_score", gf.score, 0);
        chk("rst_game_reset", gf.game_reset, 0);
        chk("rst_frame_tick", gf.frame_tick, 0);
        steps(3);
        Reset_n = 1;

        foreach (tbl[i]) begin
            gf.keycode = tbl[i].kc;
            gf.is_dead_girl = tbl[i].dead;
            gf.is_diamond_eat = tbl[i].dia;
            gf.at_exit = tbl[i].ex;
            steps(tbl[i].ncyc);
            chk($sformatf("tbl%0d_status", i), gf.status, tbl[i].st);
            chk($sformatf("tbl%0d_score", i), gf.score, tbl[i].sc);
            if (tbl[i].fd >= 0) chk($sformatf("tbl%0d_fade", i), gf.fade_level, tbl[i].fd);
            chk($sformatf("tbl%0d_resets", i), n_resets, tbl[i].rs);
        end
        gf.is_dead_girl = 0; gf.is_diamond_eat = 0; gf.at_exit = 0; gf.keycode = 8'h00;

        // asynchronous reset in the middle of the death fade
        gf.is_dead_girl = 1;
        found = 0;
        for (int k = 0; k < 600 && !found; k++) begin
            step();
            if (m_status == 2 && m_fade == 10) found = 1;
        end
        gf.is_dead_girl = 0;
        chk("reach_fade10", found, 1);
        chk("fade10", gf.fade_level, 10);
        Reset_n = 0;
        #2;
        chk("async_status", gf.status, 0);
        chk("async_freeze", gf.freeze, 1);
        chk("async_fade", gf.fade_level, 0);
        chk("async_score", gf.score, 0);
        chk("async_game_reset", gf.game_reset, 0);
        chk("async_frame_tick", gf.frame_tick, 0);
        base = n_resets;
        step();
        Reset_n = 1;
        steps(40);
        chk("post_rst_title", gf.status, 0);
        chk("post_rst_no_pulse", n_resets, base);

        // pause key with a diamond edge while (possibly) paused
        gf.keycode = 8'h28; steps(4);
        gf.keycode = 8'h00; steps(2);
        gf.keycode = 8'h13; steps(4);
        chk("p1_status", gf.status, P_ST);
        chk("p1_freeze", gf.freeze, (P_ST != 1));
        gf.is_diamond_eat = 1; steps(2);
        gf.is_diamond_eat = 0; steps(2);
        chk("p_score", gf.score, P_SCORE);
        base = n_resets;
        gf.keycode = 8'h00; steps(2);
        gf.keycode = 8'h13; steps(4);
        chk("p2_status", gf.status, 1);
        chk("p2_no_pulse", n_resets, base);
        gf.keycode = 8'h00; steps(2);

        // randomized stimulus against the model
        kc_opts[0] = 8'h00; kc_opts[1] = 8'h00; kc_opts[2] = 8'h28;
        kc_opts[3] = 8'h29; kc_opts[4] = 8'h13; kc_opts[5] = 8'h04;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 8) begin
                gf.keycode = kc_opts[$urandom_range(0, 5)];
                if (gf.keycode == 8'h04) gf.keycode = 8'($urandom_range(0, 255));
            end
            gf.is_dead_girl = ($urandom_range(0, 11) == 0);
            gf.at_exit = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 2) == 0) gf.is_diamond_eat = ~gf.is_diamond_eat;
            Reset_n = ($urandom_range(0, 1499) != 0);
            step();
        end
        Reset_n = 1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/game_flow_controller.md
GAME_FLOW_CONTROLLER -- requirements
Module: game_flow_controller

Interface
REQ-001 Parameter FADE_FRAMES, default 32, sets the number of frames in the death fade (range 2..32).
REQ-002 Parameter DIAMONDS_TOTAL, default 1, sets the diamonds required to clear the level (range 1..15).
REQ-003 Parameter CLEAR_HOLD_FRAMES, default 120, sets the frames the CLEAR screen is held (range 1..255).
REQ-004 Clk  in  1  system clock, 50 MHz.
REQ-005 Reset_n  in  1  asynchronous, active-low reset.
REQ-006 frame_clk  in  1  VGA_VS, asynchronous to Clk; its rising edge marks a new frame.
REQ-007 keycode  in  8  current USB keycode, 0x00 when idle.
REQ-008 is_dead_girl  in  1  level, player touched a hazard.
REQ-009 is_diamond_eat  in  1  level; each rising edge is one diamond collected.
REQ-010 at_exit  in  1  level, player is on the exit door.
REQ-011 status  out  4  game state code to the color mapper: 0 TITLE, 1 PLAY, 2 DYING, 3 GAME_OVER, 4 CLEAR, 5 PAUSE.
REQ-012 game_reset  out  1  one-cycle pulse that restarts the motion modules.
REQ-013 freeze  out  1  high when motion modules must hold position.
REQ-014 fade_level  out  5  death fade intensity, 0..FADE_FRAMES-1.
REQ-015 score  out  4  diamonds collected.
REQ-016 frame_tick  out  1  one-cycle pulse per frame.

Function
REQ-017 frame_clk SHALL pass through a 2-flop synchronizer followed by a rising-edge detect; frame_tick SHALL assert exactly 3 Clk cycles after the frame_clk rising edge, for 1 cycle.
REQ-018 A key press event SHALL be defined as keycode == K in the current cycle and the registered previous keycode != K; holding a key SHALL yield exactly one event.
REQ-019 ENTER = 0x28 and ESC = 0x29.
REQ-020 In TITLE, an ENTER press SHALL move the FSM to PLAY on the next edge and pulse game_reset in that same cycle.
REQ-021 In PLAY, at frame_tick with is_dead_girl=1, the FSM SHALL go to DYING with fade_level cleared to 0.
REQ-022 In PLAY, at frame_tick with at_exit=1 and score>=DIAMONDS_TOTAL, the FSM SHALL go to CLEAR with the hold counter cleared.
REQ-023 When death and exit conditions occur on the same frame_tick, DYING SHALL win.
REQ-024 In DYING, fade_level SHALL increment on each frame_tick; at frame_tick with fade_level==FADE_FRAMES-1 the FSM SHALL go to GAME_OVER and fade_level SHALL hold FADE_FRAMES-1.
REQ-025 In GAME_OVER, an ENTER press SHALL go to PLAY with a game_reset pulse; an ESC press SHALL go to TITLE; all other keys SHALL be ignored.
REQ-026 In CLEAR, the hold counter SHALL increment per frame_tick; reaching CLEAR_HOLD_FRAMES or an ENTER press SHALL go to TITLE.
REQ-027 Score SHALL increment on each rising edge of is_diamond_eat only while in PLAY, saturate at 15, and clear on game_reset.
REQ-028 freeze SHALL be combinationally high whenever status != 1.
REQ-029 fade_level SHALL read 0 in every state except DYING and GAME_OVER.
REQ-030 Unused state encodings SHALL recover to TITLE on the next edge.

Reset
REQ-031 Reset_n low SHALL immediately force: status=0 (TITLE), game_reset=0, freeze=1, fade_level=0, score=0, frame_tick=0; synchronizer, previous-keycode and counter registers SHALL be cleared.
REQ-032 Reset asserted mid-DYING or mid-CLEAR SHALL abandon the sequence with no game_reset pulse; after release, the FSM SHALL wait in TITLE.

Configuration
REQ-033 Macro GAME_PAUSE_EN: when defined, a P press (0x13) in PLAY SHALL go to PAUSE (status 5, freeze=1); a second P press SHALL return to PLAY without game_reset. Score and counters SHALL hold while paused, and the death and exit conditions SHALL be ignored in PAUSE.
REQ-034 Without GAME_PAUSE_EN, keycode 0x13 SHALL be ignored and status 5 SHALL never occur.

Verification
REQ-035 Reset release, keycode=0x28 for 10 cycles -> exactly one game_reset pulse, status 0->1, score=0.
REQ-036 PLAY, three is_diamond_eat rising edges, then at_exit=1 with DIAMONDS_TOTAL=3 -> score=3; status=4 after the next frame_tick; status=0 after 120 frame_ticks.
REQ-037 PLAY, is_dead_girl=1 and at_exit=1 (score sufficient) on the same frame -> status=2; fade_level counts 0..31 over 32 frame_ticks; then status=3, fade_level=31.
REQ-038 GAME_OVER, keycode 0x29 -> status=0; a repeat run with keycode 0x28 -> status=1, game_reset pulse, score=0.
REQ-039 DYING at fade_level=10, Reset_n low for 1 cycle -> all outputs at reset values asynchronously, no game_reset pulse.
REQ-040 With GAME_PAUSE_EN defined: 0x13 press -> status=5, freeze=1, is_diamond_eat edge leaves score unchanged, second 0x13 press -> status=1; without the macro, 0x13 leaves status=1.
